// File: rtl/phase_seq_pkg.sv
// Shared types and helpers for the phase sequencer: FSM state encoding and
// the one-hot phase decode used to build the phase-enable strobes.
package phase_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_RUN        = 3'd1,
    ST_STEP_PHASE = 3'd2,
    ST_STEP_INSTR = 3'd3,
    ST_HALTED     = 3'd4
  } phase_state_t;

  localparam int MAX_PHASES = 32;

  function automatic logic [MAX_PHASES-1:0] phase_onehot(input logic [4:0] idx);
    phase_onehot = {{(MAX_PHASES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level request input: one history flop and an AND.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  // Previous-value register, cleared by the synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/phase_sequencer.sv
// Multi-phase controller: one-hot phase enables with free-run, phase-step and
// instruction-step modes; stop and halt take effect only at instruction end.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int PHASE_W    = $clog2(NUM_PHASES),
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exec,
  input  logic                  step_phase,
  input  logic                  step_instr,
  input  logic                  halt,
  output logic                  register_reset,
  output logic [PHASE_W-1:0]    phase,
  output logic [NUM_PHASES-1:0] phase_en,
  output logic                  running,
  output logic                  halted,
  output logic [CNT_W-1:0]      instr_count
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  phase_state_t       r_state, w_state_nxt;
  logic [PHASE_W-1:0] r_phase, w_phase_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic               r_stop_pend, w_stop_nxt;
  logic               r_halt_pend, w_halt_nxt;
  logic               w_exec_rise, w_sp_rise, w_si_rise;
  logic               w_active, w_last;

  rise_detect u_exec_rise (.clock(clock), .reset(reset), .i_d(exec),       .o_rise(w_exec_rise));
  rise_detect u_sp_rise   (.clock(clock), .reset(reset), .i_d(step_phase), .o_rise(w_sp_rise));
  rise_detect u_si_rise   (.clock(clock), .reset(reset), .i_d(step_instr), .o_rise(w_si_rise));

  assign w_active = (r_state == ST_RUN) || (r_state == ST_STEP_PHASE) ||
                    (r_state == ST_STEP_INSTR);
  assign w_last   = w_active && (r_phase == LAST_PHASE);

  // Next-state, phase advance, retire counting and pending-flag update
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_count_nxt = r_count;
    w_stop_nxt  = r_stop_pend;
    w_halt_nxt  = r_halt_pend;

    if (w_active) begin
      if (w_last) begin
        w_phase_nxt = '0;
        w_count_nxt = r_count + CNT_W'(1);
        w_stop_nxt  = 1'b0;
        w_halt_nxt  = 1'b0;
      end else begin
        w_phase_nxt = r_phase + PHASE_W'(1);
        w_halt_nxt  = r_halt_pend | halt;
      end
    end else begin
      w_stop_nxt = 1'b0;
      w_halt_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_exec_rise) begin
          w_state_nxt = ST_RUN;
        end else if (w_sp_rise) begin
          w_state_nxt = ST_STEP_PHASE;
        end else if (w_si_rise) begin
          w_state_nxt = ST_STEP_INSTR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          if (r_halt_pend || halt) begin
            w_state_nxt = ST_HALTED;
          end else if (r_stop_pend || w_exec_rise) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end else begin
          w_stop_nxt = r_stop_pend | w_exec_rise;
        end
      end
      ST_STEP_PHASE: begin
        if (w_last && halt) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STEP_INSTR: begin
        if (!w_last) begin
          w_state_nxt = ST_STEP_INSTR;
        end else if (r_halt_pend || halt) begin
          w_state_nxt = ST_HALTED;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HALTED: begin
        w_state_nxt = ST_HALTED;
        w_phase_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_phase_nxt = '0;
      end
    endcase
  end

  // State, phase, counter and pending-flag registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_count     <= '0;
      r_stop_pend <= 1'b0;
      r_halt_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_phase     <= w_phase_nxt;
      r_count     <= w_count_nxt;
      r_stop_pend <= w_stop_nxt;
      r_halt_pend <= w_halt_nxt;
    end
  end

  // Enables come from registered state only; never gated with the clock
  assign phase_en       = w_active ? NUM_PHASES'(phase_onehot(5'(r_phase))) : '0;
  assign register_reset = ~reset;
  assign phase          = r_phase;
  assign running        = w_active;
  assign halted         = (r_state == ST_HALTED);
  assign instr_count    = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench: stimulus queues the expected strobes, negedge monitors
// pop and compare whenever a phase enable is presented.
module tb_phase_sequencer;

  typedef struct {
    int phase;
    int cnt;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_reset, a_exec, a_sp, a_si, a_halt;
  logic        a_rr, a_running, a_halted;
  logic [2:0]  a_phase;
  logic [4:0]  a_phase_en;
  logic [15:0] a_count;

  logic        b_reset, b_exec, b_sp, b_si, b_halt;
  logic        b_rr, b_running, b_halted;
  logic [1:0]  b_phase;
  logic [2:0]  b_phase_en;
  logic [1:0]  b_count;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  phase_sequencer #(.NUM_PHASES(5), .CNT_W(16)) u_a (
    .clock(clock), .reset(a_reset), .exec(a_exec), .step_phase(a_sp),
    .step_instr(a_si), .halt(a_halt), .register_reset(a_rr), .phase(a_phase),
    .phase_en(a_phase_en), .running(a_running), .halted(a_halted),
    .instr_count(a_count)
  );

  phase_sequencer #(.NUM_PHASES(3), .CNT_W(2)) u_b (
    .clock(clock), .reset(b_reset), .exec(b_exec), .step_phase(b_sp),
    .step_instr(b_si), .halt(b_halt), .register_reset(b_rr), .phase(b_phase),
    .phase_en(b_phase_en), .running(b_running), .halted(b_halted),
    .instr_count(b_count)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_a(input int p, input int c);
    exp_t e;
    e.phase = p;
    e.cnt   = c;
    qa.push_back(e);
  endtask

  task automatic push_b(input int p, input int c);
    exp_t e;
    e.phase = p;
    e.cnt   = c;
    qb.push_back(e);
  endtask

  // Monitor for the 5-phase instance
  always @(negedge clock) begin
    if (a_phase_en != 5'd0) begin
      if (qa.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL a_unexpected_strobe: got phase_en=%b phase=%0d, expected no strobe",
                 a_phase_en, a_phase);
      end else begin
        ea = qa.pop_front();
        check("a_phase", int'(a_phase), ea.phase);
        check("a_phase_en", int'(a_phase_en), 1 << ea.phase);
        check("a_count", int'(a_count), ea.cnt);
      end
    end
  end

  // Monitor for the 3-phase, 2-bit-counter instance
  always @(negedge clock) begin
    if (b_phase_en != 3'd0) begin
      if (qb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL b_unexpected_strobe: got phase_en=%b phase=%0d, expected no strobe",
                 b_phase_en, b_phase);
      end else begin
        eb = qb.pop_front();
        check("b_phase", int'(b_phase), eb.phase);
        check("b_phase_en", int'(b_phase_en), 1 << eb.phase);
        check("b_count", int'(b_count), eb.cnt);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_reset = 1'b0; a_exec = 1'b0; a_sp = 1'b0; a_si = 1'b0; a_halt = 1'b0;
    b_reset = 1'b0; b_exec = 1'b0; b_sp = 1'b0; b_si = 1'b0; b_halt = 1'b0;

    // Reset held three cycles
    repeat (3) tick();
    check("rst_phase", int'(a_phase), 0);
    check("rst_phase_en", int'(a_phase_en), 0);
    check("rst_running", int'(a_running), 0);
    check("rst_halted", int'(a_halted), 0);
    check("rst_count", int'(a_count), 0);
    check("rst_register_reset", int'(a_rr), 1);
    check("b_rst_phase_en", int'(b_phase_en), 0);
    a_reset = 1'b1;
    b_reset = 1'b1;
    tick();
    check("register_reset_released", int'(a_rr), 0);

    // Free run for three instructions, stop requested at phase 2 of the third
    for (int k = 0; k < 15; k++) push_a(k % 5, k / 5);
    a_exec = 1'b1;
    tick();
    a_exec = 1'b0;
    for (int i = 0; i < 12; i++) begin
      a_sp = (i == 3);
      tick();
    end
    a_sp = 1'b0;
    check("run_phase_before_stop", int'(a_phase), 2);
    a_exec = 1'b1;
    tick();
    a_exec = 1'b0;
    check("run_running_after_stop_req", int'(a_running), 1);
    tick();
    tick();
    check("stop_running", int'(a_running), 0);
    check("stop_phase", int'(a_phase), 0);
    check("stop_count", int'(a_count), 3);
    tick();
    check("run_queue_drained", qa.size(), 0);

    // Three single-phase steps, then an instruction step to finish
    for (int s = 0; s < 3; s++) begin
      push_a(s, 3);
      a_sp = 1'b1;
      tick();
      a_sp = 1'b0;
      repeat (3) tick();
      check("step_phase_running", int'(a_running), 0);
    end
    check("step_phase_held", int'(a_phase), 3);
    push_a(3, 3);
    push_a(4, 3);
    a_si = 1'b1;
    tick();
    a_si = 1'b0;
    repeat (3) tick();
    check("step_instr_phase", int'(a_phase), 0);
    check("step_instr_count", int'(a_count), 4);
    check("step_instr_running", int'(a_running), 0);
    check("step_queue_drained", qa.size(), 0);

    // Halt during phase 1 waits for the instruction boundary
    for (int k = 0; k < 5; k++) push_a(k, 4);
    a_exec = 1'b1;
    tick();
    a_exec = 1'b0;
    tick();
    a_halt = 1'b1;
    tick();
    a_halt = 1'b0;
    repeat (3) tick();
    check("halt_halted", int'(a_halted), 1);
    check("halt_running", int'(a_running), 0);
    check("halt_phase", int'(a_phase), 0);
    check("halt_count", int'(a_count), 5);
    a_exec = 1'b1;
    tick();
    a_exec = 1'b0;
    repeat (3) tick();
    check("halt_ignores_exec", int'(a_halted), 1);
    check("halt_queue_drained", qa.size(), 0);
    a_reset = 1'b0;
    tick();
    a_reset = 1'b1;
    check("halt_reset_halted", int'(a_halted), 0);
    check("halt_reset_count", int'(a_count), 0);
    tick();

    // Reset mid-instruction drops enables and does not count the instruction
    for (int k = 0; k < 3; k++) push_a(k, 0);
    a_exec = 1'b1;
    tick();
    a_exec = 1'b0;
    tick();
    tick();
    a_reset = 1'b0;
    tick();
    check("midrst_phase_en", int'(a_phase_en), 0);
    check("midrst_phase", int'(a_phase), 0);
    check("midrst_count", int'(a_count), 0);
    a_reset = 1'b1;
    tick();

    // Halt and exec together at the last phase: halt wins
    for (int k = 0; k < 5; k++) push_a(k, 0);
    a_exec = 1'b1;
    tick();
    a_exec = 1'b0;
    repeat (4) tick();
    a_exec = 1'b1;
    a_halt = 1'b1;
    tick();
    a_exec = 1'b0;
    a_halt = 1'b0;
    check("simul_halted", int'(a_halted), 1);
    check("simul_count", int'(a_count), 1);
    tick();
    check("simul_queue_drained", qa.size(), 0);

    // Three-phase instance: phase and 2-bit counter both wrap
    for (int k = 0; k < 15; k++) push_b(k % 3, (k / 3) % 4);
    b_exec = 1'b1;
    tick();
    b_exec = 1'b0;
    repeat (11) tick();
    check("b_phase_k11", int'(b_phase), 2);
    check("b_count_k11", int'(b_count), 3);
    repeat (3) tick();
    check("b_count_wrapped", int'(b_count), 0);
    check("b_phase_k14", int'(b_phase), 2);
    b_reset = 1'b0;
    tick();
    b_reset = 1'b1;
    check("b_running_after_reset", int'(b_running), 0);
    tick();
    check("b_queue_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised successor to the processor's five-phase controller. Generates one-hot phase-enable strobes for NUM_PHASES pipeline phases and supports free-run, single-phase step and single-instruction step modes. Stop requests and processor `halt` are honoured only at instruction boundaries, at the end of the last phase. Enables are derived from registered state only, never ANDed with `clock`; downstream logic uses them as clock enables on `clock`.

## Interface
Parameters:
- NUM_PHASES, 5, phases per instruction (≥2)
- PHASE_W, $clog2(NUM_PHASES), phase index width
- CNT_W, 16, width of retired-instruction counter

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of `clock`
- exec  in  1  run/stop request (button level); rising edge acts
- step_phase  in  1  single-phase step request; rising edge acts
- step_instr  in  1  single-instruction step request; rising edge acts
- halt  in  1  processor halt (level); sampled only while active
- register_reset  out  1  active-high register-file reset, = ~reset (combinational)
- phase  out  PHASE_W  current phase index
- phase_en  out  NUM_PHASES  one-hot enable, bit k high when active and phase==k
- running  out  1  high in RUN, STEP_PHASE, STEP_INSTR
- halted  out  1  high in HALTED
- instr_count  out  CNT_W  completed instructions, wraps

## Operation
- States: IDLE, RUN, STEP_PHASE, STEP_INSTR, HALTED.
- Active = RUN | STEP_PHASE | STEP_INSTR. phase_en = active ? onehot(phase) : 0.
- Each request input is rising-edge detected against its registered previous value.
- Last phase: phase==NUM_PHASES-1 while active. It advances phase to 0 and increments instr_count.
- Reset (reset==0): state=IDLE, phase=0, instr_count=0, edge registers=0, stop_pend=0, halt_pend=0. Reset overrides everything.
- IDLE transitions, priority order: exec rise → RUN; else step_phase rise → STEP_PHASE; else step_instr rise → STEP_INSTR. Phase is held and may be non-zero after phase stepping; resuming continues from it.
- RUN: phase advances every cycle (wraps NUM_PHASES-1→0).
  - exec rise sets stop_pend.
  - At last phase: halt_pend or halt → HALTED; else stop_pend or exec rise → IDLE; else continue. Both pending flags clear on leaving.
- STEP_PHASE: exactly one active cycle, phase advances, then IDLE. If that cycle is the last phase and halt is high → HALTED.
- STEP_INSTR: active until the last phase inclusive, then IDLE with phase=0. If halt was seen → HALTED.
- halt seen while active and not at last phase sets halt_pend.
- HALTED: phase=0, phase_en=0. All requests ignored; only reset exits.
- Step requests arriving while active are ignored, not queued.
- instr_count wraps 2^CNT_W-1 → 0.

## Timing
- Request edge at rising edge N (input high, previous low) → state changes at edge N; first phase_en pulse is in cycle N→N+1.
- Each phase_en bit is high for exactly one clock cycle per activation, with no overlap between bits.
- Stop latency from exec rise at phase p: NUM_PHASES-1-p further active cycles, then IDLE.
- Simultaneous halt and exec at the last phase → HALTED.
- Reset mid-instruction: phase_en goes 0 at the same edge; the partial instruction is not counted.

## Structure
- Package `phase_seq_pkg`: state enum `phase_state_t` (5 values, 3-bit encoding), helper function for the one-hot decode.
- Sub-module `rise_detect` (1 flop plus AND), instanced for exec, step_phase, step_instr.
- Top contains the state FSM, phase counter, pending flags and instr_count.

## Test plan
- Reset held 3 cycles → phase=0, phase_en=0, running=0, halted=0, instr_count=0, register_reset=1.
- exec pulse, NUM_PHASES=5, run 12 cycles → phase_en sequence 1,2,4,8,16,1,… with instr_count=2 after 10 active cycles.
- exec pulse again when phase=2 → active cycles with phase 2,3,4 complete, then IDLE, phase=0, instr_count +1.
- From IDLE, three step_phase pulses spaced 4 cycles → single strobes with phase 0,1,2. Then step_instr → strobes for phases 3,4, then IDLE with phase=0.
- halt raised at phase 1 in RUN → phases 2–4 still strobe, then HALTED=1; subsequent exec ignored; reset returns to IDLE.
- NUM_PHASES=3, CNT_W=2, run 15 cycles → phase wraps 2→0 and instr_count wraps 3→0.
